montgomery_domain_encoder: RTL and testbench

Bit-serial converter that maps an ordinary residue into the Montgomery domain: result = x * 2^n mod m, where n = m_bl_i.
It produces the y operand (y*R mod m) consumed by montgomery_serialized, so the multiplier's REDC output returns to the normal domain.
It sits in front of the multiplier in the datapath and reuses the same modulus and modulus-length inputs.

---
 rtl/montgomery_domain_encoder_pkg.sv | 17 +
 rtl/montgomery_domain_encoder_mod_double_step.sv | 19 +
 rtl/montgomery_domain_encoder.sv | 112 +++++++++++
 tb/tb_montgomery_domain_encoder.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/montgomery_domain_encoder_pkg.sv
// Shared constants and state type for the Montgomery domain encoder.
// MONT_R_MOD is the reference R mod m for the default modulus.
package montgomery_domain_encoder_pkg;

  localparam int DATA_LENGTH = 32;
  localparam logic [DATA_LENGTH-1:0] MODULUS = 32'd8380417;
  localparam int MODULUS_LENGTH = 23;
  localparam logic [DATA_LENGTH-1:0] MONT_R_MOD =
    DATA_LENGTH'((64'd1 << MODULUS_LENGTH) % {32'd0, MODULUS});

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } enc_state_e;

endpackage

// File: rtl/montgomery_domain_encoder_mod_double_step.sv
// Combinational modular doubling: o_acc = 2*i_acc mod i_m, assuming i_acc < i_m.
// The subtract can run at W bits because the true result is below m < 2^W.
module mod_double_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_acc,
  input  logic [W-1:0] i_m,
  output logic [W-1:0] o_acc
);

  logic [W-1:0] w_shl;
  logic         w_ge;

  assign w_shl = {i_acc[W-2:0], 1'b0};
  // The carried-out MSB makes the (W+1)-bit value at least 2^W > m.
  assign w_ge  = i_acc[W-1] | (w_shl >= i_m);
  assign o_acc = w_ge ? (w_shl - i_m) : w_shl;

endmodule

// File: rtl/montgomery_domain_encoder.sv
// Bit-serial x*2^n mod m encoder: one modular doubling per clock, n cycles latency.
// Fault and zero-length requests complete one edge after acceptance via a pending flag in DONE.
module montgomery_domain_encoder
  import montgomery_domain_encoder_pkg::*;
#(
  parameter int DATA_LENGTH = montgomery_domain_encoder_pkg::DATA_LENGTH,
  parameter int CNT_W       = $clog2(DATA_LENGTH + 1)
) (
  input  logic                   CLK_pci_sys_clk_p,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic [DATA_LENGTH-1:0] x_i,
  input  logic [DATA_LENGTH-1:0] m_i,
  input  logic [DATA_LENGTH-1:0] m_bl_i,
  output logic [DATA_LENGTH-1:0] result_o,
  output logic                   valid_o,
  output logic                   busy_o,
  output logic                   error_o
);

  enc_state_e             r_state;
  logic [DATA_LENGTH-1:0] r_acc;
  logic [DATA_LENGTH-1:0] r_m;
  logic [CNT_W-1:0]       r_n;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_pend;
  logic                   r_flt;
  logic [DATA_LENGTH-1:0] r_result;
  logic                   r_valid;
  logic                   r_busy;
  logic                   r_error;

  logic [DATA_LENGTH-1:0] w_next_acc;
  logic                   w_fault;
  logic                   w_zero;
  logic                   w_last;

  mod_double_step #(.W(DATA_LENGTH)) u_step (
    .i_acc (r_acc),
    .i_m   (r_m),
    .o_acc (w_next_acc)
  );

  assign w_fault = (x_i >= m_i) || (m_bl_i > DATA_LENGTH'(DATA_LENGTH));
  assign w_zero  = (m_bl_i == '0);
  assign w_last  = (r_cnt == (r_n - CNT_W'(1)));

  always_ff @(posedge CLK_pci_sys_clk_p or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= IDLE;
      r_acc    <= '0;
      r_m      <= '0;
      r_n      <= '0;
      r_cnt    <= '0;
      r_pend   <= 1'b0;
      r_flt    <= 1'b0;
      r_result <= '0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start_i) begin
            r_m   <= m_i;
            r_n   <= CNT_W'(m_bl_i);
            r_cnt <= '0;
            if (w_fault || w_zero) begin
              r_acc   <= w_fault ? '0 : x_i;
              r_flt   <= w_fault;
              r_pend  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_acc   <= x_i;
              r_busy  <= 1'b1;
              r_state <= CALC;
            end
          end
        end
        CALC: begin
          r_acc <= w_next_acc;
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_result <= w_next_acc;
            r_valid  <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= DONE;
          end
        end
        DONE: begin
          if (r_pend) begin
            r_result <= r_acc;
            r_error  <= r_flt;
            r_valid  <= 1'b1;
            r_pend   <= 1'b0;
          end else begin
            r_valid <= 1'b0;
            r_error <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign result_o = r_result;
  assign valid_o  = r_valid;
  assign busy_o   = r_busy;
  assign error_o  = r_error;

endmodule

// File: tb/tb_montgomery_domain_encoder.sv
// Self-checking bench: directed Test Plan vectors plus a random sweep checked
// against x*2^n mod m computed with wide integer arithmetic.
module tb_montgomery_domain_encoder;

  localparam int DL = 32;
  localparam logic [31:0] M0 = 32'd8380417;
  localparam logic [31:0] N0 = 32'd23;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [DL-1:0] x, m, nbl;
  logic [DL-1:0] result;
  logic          valid, busy, error;

  int n_checks = 0;
  int n_pass   = 0;

  montgomery_domain_encoder dut (
    .CLK_pci_sys_clk_p (clk),
    .rst_ni            (rst_n),
    .start_i           (start),
    .x_i               (x),
    .m_i               (m),
    .m_bl_i            (nbl),
    .result_o          (result),
    .valid_o           (valid),
    .busy_o            (busy),
    .error_o           (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_enc(input logic [31:0] xv, input logic [31:0] mv,
                                          input int nv);
    logic [127:0] wide;
    wide = ({96'd0, xv} << nv) % {96'd0, mv};
    return wide[31:0];
  endfunction

  // Issues one request and waits (bounded) for valid; reports latency in edges after E0.
  task automatic do_req(input logic [31:0] xv, input logic [31:0] mv, input logic [31:0] nv,
                        output logic [31:0] res, output logic err, output int lat,
                        output int busy_cyc);
    @(negedge clk);
    x = xv; m = mv; nbl = nv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1; busy_cyc = 0; res = '0; err = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (busy) busy_cyc++;
      @(posedge clk); #1;
      if (valid) begin
        lat = k; res = result; err = error;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; x = '0; m = '0; nbl = '0;
    #12;
    n_checks++;
    if ({result, valid, busy, error} !== 35'd0)
      $display("FAIL reset_outputs: got result=%0d valid=%b busy=%b error=%b, want all 0",
               result, valid, busy, error);
    else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL reset_idle: got valid=%b busy=%b, want 0 0", valid, busy);
    else n_pass++;
  endtask

  task automatic test_known();
    logic [31:0] xs[5];
    logic [31:0] ex[5];
    logic [31:0] res; logic err; int lat, bc;
    xs = '{32'd1, 32'd8380416, 32'd0, 32'd2, 32'd5};
    ex = '{32'd8191, 32'd8372226, 32'd0, 32'd16382, 32'd40955};
    for (int i = 0; i < 5; i++) begin
      do_req(xs[i], M0, N0, res, err, lat, bc);
      n_checks++;
      if (res !== ex[i] || err !== 1'b0)
        $display("FAIL known_result x=%0d: got %0d err=%b, want %0d err=0", xs[i], res, err, ex[i]);
      else n_pass++;
      n_checks++;
      if (lat != 23 || bc != 23)
        $display("FAIL known_timing x=%0d: got latency=%0d busy=%0d, want 23 23", xs[i], lat, bc);
      else n_pass++;
      @(posedge clk); #1;
      n_checks++;
      if (valid !== 1'b0 || result !== ex[i])
        $display("FAIL valid_pulse_hold x=%0d: got valid=%b result=%0d, want 0 %0d",
                 xs[i], valid, result, ex[i]);
      else n_pass++;
    end
  endtask

  task automatic test_fault_and_zero();
    logic [31:0] res; logic err; int lat, bc;
    do_req(M0, M0, N0, res, err, lat, bc);
    n_checks++;
    if (res !== 32'd0 || err !== 1'b1 || lat != 1 || bc != 0)
      $display("FAIL fault_x_eq_m: got res=%0d err=%b lat=%0d busy=%0d, want 0 1 1 0", res, err, lat, bc);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (valid !== 1'b0 || error !== 1'b0)
      $display("FAIL fault_clear: got valid=%b error=%b, want 0 0", valid, error);
    else n_pass++;
    do_req(32'd1, M0, 32'd33, res, err, lat, bc);
    n_checks++;
    if (res !== 32'd0 || err !== 1'b1 || lat != 1)
      $display("FAIL fault_len: got res=%0d err=%b lat=%0d, want 0 1 1", res, err, lat);
    else n_pass++;
    @(posedge clk);
    do_req(32'd1234, M0, 32'd0, res, err, lat, bc);
    n_checks++;
    if (res !== 32'd1234 || err !== 1'b0 || lat != 1)
      $display("FAIL zero_len: got res=%0d err=%b lat=%0d, want 1234 0 1", res, err, lat);
    else n_pass++;
    @(posedge clk);
    do_req(32'd7, 32'd11, 32'd32, res, err, lat, bc);
    n_checks++;
    if (res !== ref_enc(32'd7, 32'd11, 32) || err !== 1'b0 || lat != 32)
      $display("FAIL max_len: got res=%0d err=%b lat=%0d, want %0d 0 32",
               res, err, lat, ref_enc(32'd7, 32'd11, 32));
    else n_pass++;
    @(posedge clk);
  endtask

  task automatic test_random();
    logic [31:0] res, xv, mv, exp_r; logic err; int lat, bc, nv, bad;
    bad = 0;
    for (int i = 0; i < 150; i++) begin
      mv = $urandom | 32'd1;
      if (mv == 32'd1) mv = 32'd3;
      nv = $urandom_range(1, 32);
      xv = $urandom % mv;
      exp_r = ref_enc(xv, mv, nv);
      do_req(xv, mv, 32'(nv), res, err, lat, bc);
      n_checks++;
      if (res !== exp_r || err !== 1'b0 || lat != nv) begin
        if (bad < 5)
          $display("FAIL random x=%0d m=%0d n=%0d: got %0d err=%b lat=%0d, want %0d 0 %0d",
                   xv, mv, nv, res, err, lat, exp_r, nv);
        bad++;
      end else n_pass++;
      @(posedge clk);
    end
  endtask

  task automatic test_back_to_back();
    int hits[$];
    int prev_v;
    @(negedge clk);
    x = 32'd1; m = M0; nbl = N0; start = 1'b1;
    prev_v = 0;
    for (int c = 0; c < 90; c++) begin
      @(posedge clk); #1;
      if (valid) begin
        hits.push_back(c);
        n_checks++;
        if (prev_v != 0 || result !== 32'd8191)
          $display("FAIL b2b_pulse cycle %0d: got result=%0d prev_valid=%0d, want 8191 0",
                   c, result, prev_v);
        else n_pass++;
      end
      prev_v = valid ? 1 : 0;
    end
    start = 1'b0;
    n_checks++;
    if (hits.size() < 3)
      $display("FAIL b2b_count: got %0d pulses, want >= 3", hits.size());
    else if (hits[1] - hits[0] != 25 || hits[2] - hits[1] != 25)
      $display("FAIL b2b_interval: got %0d %0d, want 25 25", hits[1] - hits[0], hits[2] - hits[1]);
    else n_pass++;
    repeat (30) @(posedge clk);
  endtask

  task automatic test_ignore_mid_calc();
    int lat, pulses;
    logic [31:0] res;
    @(negedge clk);
    x = 32'd3; m = M0; nbl = N0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1; pulses = 0; res = '0;
    for (int k = 1; k <= 60; k++) begin
      if (k == 5) begin start = 1'b1; x = 32'd7; end
      if (k == 6) start = 1'b0;
      @(posedge clk); #1;
      if (valid) begin
        pulses++;
        if (lat < 0) begin lat = k; res = result; end
      end
    end
    n_checks++;
    if (res !== 32'd24573 || lat != 23 || pulses != 1)
      $display("FAIL ignore_mid_calc: got res=%0d lat=%0d pulses=%0d, want 24573 23 1", res, lat, pulses);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] res; logic err; int lat, bc, seen;
    @(negedge clk);
    x = 32'd1; m = M0; nbl = N0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({result, valid, busy, error} !== 35'd0)
      $display("FAIL reset_mid_async: got result=%0d valid=%b busy=%b error=%b, want all 0",
               result, valid, busy, error);
    else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (valid) seen++;
    end
    n_checks++;
    if (seen != 0)
      $display("FAIL reset_mid_novalid: got %0d valid cycles, want 0", seen);
    else n_pass++;
    do_req(32'd1, M0, N0, res, err, lat, bc);
    n_checks++;
    if (res !== 32'd8191 || err !== 1'b0 || lat != 23)
      $display("FAIL reset_mid_recover: got res=%0d err=%b lat=%0d, want 8191 0 23", res, err, lat);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_known();
    test_fault_and_zero();
    test_random();
    test_back_to_back();
    test_ignore_mid_calc();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
